ctrl_pipeline: RTL and testbench
================================

# ctrl_pipeline

Parametrised control-signal pipeline for the in-order core. It replaces hand-instantiated per-stage control registers with a STAGES-deep chain that carries a W-bit decoded control bundle plus a valid bit. Each stage has its own stall (hold) and flush (clear), stalls propagate upstream as backpressure, and bubbles are inserted automatically. It sits between the decoders in ID and the EX/MEM/WB consumers, and also provides a retired-instruction counter.

## Interface
Parameters:
- STAGES, 3, number of stage registers; stage 0 = ID/EX, stage STAGES-1 = last (WB side); ≥1
- W, 25, control bundle width; ≥1
- CNT_W, 64, retire counter width; ≥1

Ports:
- clk  in  1  clock, rising edge
- reset_x  in  1  asynchronous, active-low reset
- i_valid  in  1  ID holds a valid instruction
- i_ctrl  in  W  decoded control bundle from ID
- i_stall  in  STAGES  bit k: stage k requests hold (e.g. multi-cycle op)
- i_flush  in  STAGES  bit k: kill the value stage k would capture on this edge
- o_ready  out  1  stage 0 captures on this edge; ID must hold its instruction when 0
- o_valid  out  STAGES  registered valid per stage
- o_ctrl  out  STAGES*W  stage k bundle at [k*W +: W]
- o_retire  out  1  last-stage entry leaves this cycle
- o_retire_cnt  out  CNT_W  registered count of retirements
- o_occupancy  out  $clog2(STAGES+1)  number of valid stages (combinational popcount)

## Operation
- hold[k] = o_valid[k] & (i_stall[k] | (k<STAGES-1 & hold[k+1])). Stalls on empty stages are ignored.
- Stage k with !hold[k] loads from stage k-1 (from i_valid/i_ctrl for k=0).
  - If the source is itself holding, stage k loads a bubble instead: valid=0, ctrl=0.
- o_ready = !hold[0]. Input is accepted iff i_valid & o_ready.
- Flush: i_flush[k]=1 forces stage k's next state to valid=0, ctrl=0.
  - Overrides both hold and load.
  - Does not affect the value stage k+1 captures from stage k on the same edge.
- Invariant: o_valid[k]=0 ⇒ o_ctrl stage k == 0, so consumers may decode o_ctrl without gating.
- o_retire = o_valid[STAGES-1] & !i_stall[STAGES-1].
  - Flush of the last stage does not suppress the retire of its current entry.
- o_retire_cnt increments by 1 on every edge where o_retire=1. Wraps from 2^CNT_W-1 to 0 with no flag.

## Timing
- Reset (reset_x low, immediate): all o_valid=0, all o_ctrl=0, o_retire_cnt=0. Consequently o_ready=1, o_retire=0, o_occupancy=0.
- Latency: an entry accepted at edge t is visible at stage k after edge t+k. Throughput is 1 entry/cycle with no stalls.
- o_ready, o_retire and o_occupancy are combinational from registered state plus i_stall. The hold chain is a ripple path of depth STAGES from i_stall[STAGES-1] to o_ready.
- Simultaneous hold and flush on a stage: flush wins, and the stage becomes a bubble next cycle.
- Reset asserted mid-stream: all in-flight entries are discarded. Counting restarts at 0 after release.
- No combinational path from i_ctrl or i_valid to any output.

## Structure
- Package pipe_pkg: default widths and stage index constants ST_EX=0, ST_MEM=1, ST_WB=2. Used by consumers to slice o_ctrl.
- Sub-module pipe_stage_reg: a (W+1)-bit register with async active-low reset, enable, and synchronous clear. Instantiated STAGES times in a generate loop.
- Hold chain, retire counter and popcount live in the top module.

## Test plan
- Reset, then stream A,B,C (i_valid=1, no stall/flush), STAGES=3. Required:
  - A appears at stage 2 after edge 3.
  - o_retire high in cycles 3,4,5.
  - o_retire_cnt=3 afterwards.
  - o_ready is 1 throughout.
- Pipe full, i_stall[1]=1 for 2 cycles. Required:
  - Stages 0 and 1 hold and o_ready=0.
  - Stage 2 gets a bubble (valid 0, ctrl 0), and o_retire drops after one cycle.
  - On release, flow resumes with no entry lost or duplicated.
- i_stall[2]=1 while stage 2 is empty. Required: no hold and o_ready stays 1.
- i_flush[0] and i_flush[1] asserted with new input accepted. Required:
  - Both stages become bubbles.
  - Stage 2 still captures the old stage-1 entry.
  - o_retire_cnt excludes the killed entries.
- CNT_W=4 with 17 continuous retirements. Required: o_retire_cnt reads 1 (wrapped through 0).
- reset_x pulled low mid-cycle with the pipe full. Required:
  - o_valid=0 and o_retire_cnt=0 immediately, without waiting for a clock edge.
  - After release, the first accepted entry flows normally.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: default ctrl_pipeline widths and stage indices consumers use to slice o_ctrl
package pipe_pkg;
  localparam int STAGES_DEF = 3;
  localparam int W_DEF = 25;
  localparam int CNT_W_DEF = 64;
  localparam int ST_EX = 0;
  localparam int ST_MEM = 1;
  localparam int ST_WB = 2;
endpackage

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: {valid,ctrl} register; async active-low reset_x, en loads d, clr (wins over en) zeroes it
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic       clk,
  input  logic       reset_x,
  input  logic       en,
  input  logic       clr,
  input  logic [W:0] d,
  output logic [W:0] q
);
  logic [W:0] q_q, q_d;
  always_comb q_d = clr ? '0 : en ? d : q_q;
  always_ff @(posedge clk or negedge reset_x)
    if (!reset_x) q_q <= '0;
    else q_q <= q_d;
  assign q = q_q;
endmodule

// File: rtl/ctrl_pipeline.sv
// ctrl_pipeline: STAGES-deep valid+ctrl chain with per-stage stall/flush, backpressure (o_ready), retire pulse/counter, occupancy
module ctrl_pipeline
  import pipe_pkg::*;
#(
  parameter int STAGES = STAGES_DEF,
  parameter int W = W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                             clk,
  input  logic                             reset_x,
  input  logic                             i_valid,
  input  logic [W-1:0]                     i_ctrl,
  input  logic [STAGES-1:0]                i_stall,
  input  logic [STAGES-1:0]                i_flush,
  output logic                             o_ready,
  output logic [STAGES-1:0]                o_valid,
  output logic [STAGES*W-1:0]              o_ctrl,
  output logic                             o_retire,
  output logic [CNT_W-1:0]                 o_retire_cnt,
  output logic [$clog2(STAGES+1)-1:0]      o_occupancy
);
  localparam int OCC_W = $clog2(STAGES+1);
  logic [W:0] st_d [STAGES];
  logic [W:0] st_q [STAGES];
  logic [STAGES-1:0] valid, hold;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
  logic [OCC_W-1:0] occ;
  always_comb begin
    valid = '0;
    o_ctrl = '0;
    for (int i = 0; i < STAGES; i++) begin
      valid[i] = st_q[i][W];
      o_ctrl[i*W +: W] = st_q[i][W-1:0];
    end
  end
  // stalls on empty stages are ignored, so a bubble absorbs backpressure
  always_comb begin
    hold = '0;
    hold[STAGES-1] = valid[STAGES-1] & i_stall[STAGES-1];
    for (int i = STAGES-2; i >= 0; i--) hold[i] = valid[i] & (i_stall[i] | hold[i+1]);
  end
  // a stage behind a holding source takes a bubble rather than a duplicate
  always_comb begin
    st_d[0] = {i_valid, i_valid ? i_ctrl : W'(0)};
    for (int i = 1; i < STAGES; i++) st_d[i] = hold[i-1] ? '0 : st_q[i-1];
  end
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    pipe_stage_reg #(.W(W)) u_reg (
      .clk     (clk),
      .reset_x (reset_x),
      .en      (!hold[k]),
      .clr     (i_flush[k]),
      .d       (st_d[k]),
      .q       (st_q[k])
    );
  end
  always_comb begin
    occ = '0;
    for (int i = 0; i < STAGES; i++) occ = occ + OCC_W'(valid[i]);
  end
  always_comb begin
    o_ready = !hold[0];
    o_retire = valid[STAGES-1] & !i_stall[STAGES-1];
    retire_cnt_d = retire_cnt_q + CNT_W'(o_retire);
    o_valid = valid;
    o_occupancy = occ;
    o_retire_cnt = retire_cnt_q;
  end
  always_ff @(posedge clk or negedge reset_x)
    if (!reset_x) retire_cnt_q <= '0;
    else retire_cnt_q <= retire_cnt_d;
endmodule

// File: tb/tb_ctrl_pipeline.sv
// tb_ctrl_pipeline: directed vectors checked against a stage-list model plus hand-computed literals
module tb_ctrl_pipeline;
  localparam int S = 3;
  localparam int W = 8;
  localparam int CW = 4;
  logic clk = 0;
  logic reset_x = 0;
  logic i_valid = 0;
  logic [W-1:0] i_ctrl = '0;
  logic [S-1:0] i_stall = '0;
  logic [S-1:0] i_flush = '0;
  logic o_ready, o_retire;
  logic [S-1:0] o_valid;
  logic [S*W-1:0] o_ctrl;
  logic [CW-1:0] o_retire_cnt;
  logic [1:0] o_occupancy;
  int checks = 0;
  int errors = 0;
  logic [2:0] mv;
  logic [W-1:0] mc [3];
  int mcnt;
  ctrl_pipeline #(.STAGES(S), .W(W), .CNT_W(CW)) dut (
    .clk(clk), .reset_x(reset_x), .i_valid(i_valid), .i_ctrl(i_ctrl),
    .i_stall(i_stall), .i_flush(i_flush), .o_ready(o_ready), .o_valid(o_valid),
    .o_ctrl(o_ctrl), .o_retire(o_retire), .o_retire_cnt(o_retire_cnt), .o_occupancy(o_occupancy)
  );
  always #5 clk = ~clk;
  function automatic logic [2:0] mhold();
    logic [2:0] h;
    h[2] = mv[2] & i_stall[2];
    h[1] = mv[1] & (i_stall[1] | h[2]);
    h[0] = mv[0] & (i_stall[0] | h[1]);
    return h;
  endfunction
  // model: list of three slots; each edge every slot either keeps, takes its predecessor, takes a bubble, or is killed
  always @(posedge clk or negedge reset_x) begin
    logic [2:0] h, nv;
    logic [W-1:0] nc [3];
    if (!reset_x) begin
      mv = '0;
      for (int i = 0; i < 3; i++) mc[i] = '0;
      mcnt = 0;
    end else begin
      h = mhold();
      if (mv[2] && !i_stall[2]) mcnt = (mcnt + 1) % 16;
      for (int i = 0; i < 3; i++) begin
        if (i_flush[i]) begin nv[i] = 0; nc[i] = '0; end
        else if (h[i]) begin nv[i] = mv[i]; nc[i] = mc[i]; end
        else if (i == 0) begin nv[i] = i_valid; nc[i] = i_valid ? i_ctrl : '0; end
        else if (h[i-1]) begin nv[i] = 0; nc[i] = '0; end
        else begin nv[i] = mv[i-1]; nc[i] = mc[i-1]; end
      end
      mv = nv;
      for (int i = 0; i < 3; i++) mc[i] = nc[i];
    end
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic compare_all();
    logic [2:0] h;
    h = mhold();
    chk("ready", 64'(o_ready), 64'(!h[0]));
    chk("valid", 64'(o_valid), 64'(mv));
    chk("ctrl", 64'(o_ctrl), 64'({mc[2], mc[1], mc[0]}));
    chk("retire", 64'(o_retire), 64'(mv[2] & !i_stall[2]));
    chk("retire_cnt", 64'(o_retire_cnt), 64'(mcnt));
    chk("occupancy", 64'(o_occupancy), 64'(mv[0] + mv[1] + mv[2]));
  endtask
  task automatic drive(input logic v, input logic [W-1:0] c, input logic [S-1:0] st, input logic [S-1:0] fl);
    i_valid = v; i_ctrl = c; i_stall = st; i_flush = fl;
  endtask
  task automatic step();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    #1;
  endtask
  task automatic tick(input logic v, input logic [W-1:0] c, input logic [S-1:0] st, input logic [S-1:0] fl);
    drive(v, c, st, fl);
    step();
  endtask
  initial begin
    #1;
    chk("rst_valid", 64'(o_valid), 0);
    chk("rst_cnt", 64'(o_retire_cnt), 0);
    chk("rst_ready", 64'(o_ready), 1);
    chk("rst_occ", 64'(o_occupancy), 0);
    @(posedge clk); #1 reset_x = 1;
    tick(1, 8'h11, 0, 0);
    tick(1, 8'h22, 0, 0);
    tick(1, 8'h33, 0, 0);
    chk("A_at_wb", 64'(o_ctrl[23:16]), 64'h11);
    chk("full_valid", 64'(o_valid), 64'h7);
    chk("retire_c3", 64'(o_retire), 1);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0);
    chk("cnt_after_abc", 64'(o_retire_cnt), 3);
    tick(1, 8'h44, 0, 0);
    tick(1, 8'h55, 0, 0);
    tick(1, 8'h66, 0, 0);
    drive(1, 8'h77, 3'b010, 0);
    #1 chk("stall_ready", 64'(o_ready), 0);
    step();
    chk("stall_valid", 64'(o_valid), 64'h3);
    chk("stall_bubble", 64'(o_ctrl[23:16]), 0);
    chk("stall_hold", 64'(o_ctrl[15:0]), 64'h5566);
    tick(1, 8'h77, 3'b010, 0);
    chk("stall_no_retire", 64'(o_retire), 0);
    tick(1, 8'h77, 0, 0);
    chk("resume", 64'(o_ctrl), 64'h556677);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0);
    chk("cnt_after_stall", 64'(o_retire_cnt), 7);
    drive(1, 8'h88, 3'b100, 0);
    #1 chk("empty_stall_ready", 64'(o_ready), 1);
    step();
    tick(1, 8'h99, 0, 0);
    tick(1, 8'haa, 0, 0);
    tick(1, 8'hbb, 0, 3'b011);
    chk("flush_valid", 64'(o_valid), 64'h4);
    chk("flush_ctrl", 64'(o_ctrl), 64'h990000);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0);
    chk("cnt_after_flush", 64'(o_retire_cnt), 9);
    tick(1, 8'hc1, 0, 0);
    tick(1, 8'hc2, 0, 0);
    tick(1, 8'hc3, 0, 0);
    tick(1, 8'hc4, 3'b010, 3'b010);
    chk("hold_flush_valid", 64'(o_valid), 64'h1);
    chk("hold_flush_ctrl", 64'(o_ctrl), 64'h0000c3);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0);
    chk("cnt_after_hf", 64'(o_retire_cnt), 11);
    tick(1, 8'hd1, 0, 0);
    tick(1, 8'hd2, 0, 0);
    tick(1, 8'hd3, 0, 0);
    #2 reset_x = 0;
    #1;
    chk("async_valid", 64'(o_valid), 0);
    chk("async_cnt", 64'(o_retire_cnt), 0);
    chk("async_ctrl", 64'(o_ctrl), 0);
    drive(0, 0, 0, 0);
    step();
    step();
    reset_x = 1;
    for (int i = 0; i < 17; i++) begin
      tick(1, 8'(8'he0 + i), 0, 0);
      if (i == 2) chk("post_rst_first", 64'(o_ctrl[23:16]), 64'he0);
    end
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0);
    chk("wrap_cnt", 64'(o_retire_cnt), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
